// File: rtl/difftest_arch_event_collector.sv
// difftest_arch_event_collector: queues commit-stage trap events in a FIFO and presents each one to the ArchEvent sink as a single registered pulse.
// Ports:
//   clock, reset            - clock and asynchronous active-high reset
//   in_valid, in_interrupt, in_exception, in_pc, in_inst
//                           - trap report from the commit stage
//   sink_ready              - sink may take an event this cycle
//   out_enable, out_valid   - one-cycle pulse per emitted event
//   out_interrupt, out_exception, out_exceptionPC, out_exceptionInst
//                           - registered event fields, held between pulses
//   out_coreid              - constant CORE_ID
//   overflow                - sticky flag, set when an event is dropped
//   event_count             - emitted events, wraps modulo 2^32
module difftest_arch_event_collector #(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] CORE_ID = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_interrupt,
    input  logic [31:0] in_exception,
    input  logic [63:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        sink_ready,
    output logic        out_enable,
    output logic        out_valid,
    output logic [31:0] out_interrupt,
    output logic [31:0] out_exception,
    output logic [63:0] out_exceptionPC,
    output logic [31:0] out_exceptionInst,
    output logic [7:0]  out_coreid,
    output logic        overflow,
    output logic [31:0] event_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [159:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [159:0]  entry;
    logic          enq;
    logic          deq;
    logic          full;
    logic          push;
    logic          drop;

    always_comb begin
        enq   = in_valid && (in_interrupt != 32'd0 || in_exception != 32'd0);
        full  = count == FULL_CNT;
        deq   = count != '0 && sink_ready;
        // A full FIFO still accepts when the head leaves on the same edge.
        push  = enq && (!full || deq);
        drop  = enq && full && !deq;
        // Interrupt wins over a simultaneous exception, as the sink expects.
        entry = {in_interrupt, (in_interrupt != 32'd0) ? 32'd0 : in_exception, in_pc, in_inst};
    end

    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= entry;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, deq};
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_enable        <= 1'b0;
            out_interrupt     <= '0;
            out_exception     <= '0;
            out_exceptionPC   <= '0;
            out_exceptionInst <= '0;
            event_count       <= '0;
        end else begin
            out_enable <= deq;
            if (deq) {out_interrupt, out_exception, out_exceptionPC, out_exceptionInst} <= mem[rd_ptr];
            // Counted on the loading edge so the count already includes the pulse being shown.
            event_count <= event_count + {31'd0, deq};
        end
    end

    assign out_valid  = out_enable;
    assign out_coreid = CORE_ID;
endmodule

// File: tb/tb_difftest_arch_event_collector.sv
// tb_difftest_arch_event_collector: directed scoreboard bench for difftest_arch_event_collector.
// Ports: none (top-level bench).
module tb_difftest_arch_event_collector;
    localparam logic [7:0] CID = 8'h5A;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] e;
        logic [63:0] pc;
        logic [31:0] inst;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_interrupt = '0;
    logic [31:0] in_exception = '0;
    logic [63:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        sink_ready = 1'b0;
    logic        out_enable;
    logic        out_valid;
    logic [31:0] out_interrupt;
    logic [31:0] out_exception;
    logic [63:0] out_exceptionPC;
    logic [31:0] out_exceptionInst;
    logic [7:0]  out_coreid;
    logic        overflow;
    logic [31:0] event_count;

    difftest_arch_event_collector #(.DEPTH(4), .CORE_ID(CID)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .in_interrupt(in_interrupt), .in_exception(in_exception),
        .in_pc(in_pc), .in_inst(in_inst), .sink_ready(sink_ready),
        .out_enable(out_enable), .out_valid(out_valid),
        .out_interrupt(out_interrupt), .out_exception(out_exception),
        .out_exceptionPC(out_exceptionPC), .out_exceptionInst(out_exceptionInst),
        .out_coreid(out_coreid), .overflow(overflow), .event_count(event_count)
    );

    always #5 clock = ~clock;

    ev_t   sb[$];
    ev_t   head;
    int    pcyc[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    pulses = 0;
    int    drive_cyc = 0;
    int    p0 = 0;
    logic [31:0] exp_cnt = '0;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (out_enable === 1'b1) begin
            pulses++;
            pcyc.push_back(cyc);
            if (sb.size() == 0) chk("unexpected_pulse", 64'd1, 64'd0);
            else begin
                head = sb.pop_front();
                chk("out_interrupt", out_interrupt, head.i);
                chk("out_exception", out_exception, head.e);
                chk("out_exceptionPC", out_exceptionPC, head.pc);
                chk("out_exceptionInst", out_exceptionInst, head.inst);
                chk("out_valid", out_valid, 1);
                chk("out_coreid", out_coreid, CID);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] e, input logic [63:0] pc,
                        input logic [31:0] inst, input bit keep);
        ev_t x;
        in_valid = 1'b1;
        in_interrupt = i;
        in_exception = e;
        in_pc = pc;
        in_inst = inst;
        drive_cyc = cyc;
        if (keep && (i != 0 || e != 0)) begin
            x.i = i;
            x.e = (i != 0) ? 32'd0 : e;
            x.pc = pc;
            x.inst = inst;
            sb.push_back(x);
            exp_cnt++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        exp_cnt = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        chk("rst_enable", out_enable, 0);
        chk("rst_fields", {out_interrupt, out_exception}, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", event_count, 0);
        chk("rst_coreid", out_coreid, CID);
        reset = 1'b0;
        sink_ready = 1'b1;
        idle(3);

        // single event, latency N+2
        send(32'd0, 32'd2, 64'h80000004, 32'hFFFFFFFF, 1'b1);
        idle(6);
        chk("t1_pulses", pulses, 1);
        chk("t1_latency", pcyc[0] - drive_cyc, 2);
        chk("t1_count", event_count, 1);

        // interrupt/exception collision then null event
        send(32'd7, 32'd5, 64'h1000, 32'h13, 1'b1);
        idle(4);
        chk("t2_pulses", pulses, 2);
        send(32'd0, 32'd0, 64'h2000, 32'h17, 1'b1);
        idle(4);
        chk("t2_null_pulses", pulses, 2);
        chk("t2_count", event_count, exp_cnt);

        // backpressure overflow
        do_reset();
        sink_ready = 1'b0;
        p0 = pulses;
        for (int k = 1; k <= 5; k++) send(32'd0, k, 64'h3000 + 64'(k), 32'h100 + k, k <= 4);
        chk("t3_overflow_set", overflow, 1);
        idle(3);
        chk("t3_stalled", pulses - p0, 0);
        sink_ready = 1'b1;
        idle(8);
        chk("t3_pulses", pulses - p0, 4);
        chk("t3_back_to_back", pcyc[pcyc.size()-1] - pcyc[pcyc.size()-4], 3);
        chk("t3_count", event_count, 4);
        chk("t3_overflow_kept", overflow, 1);

        // full with simultaneous enqueue and dequeue
        do_reset();
        sink_ready = 1'b0;
        p0 = pulses;
        for (int k = 1; k <= 4; k++) send(32'd0, k, 64'h4000 + 64'(k), 32'h200 + k, 1'b1);
        sink_ready = 1'b1;
        send(32'd0, 32'd9, 64'h4009, 32'h209, 1'b1);
        idle(8);
        chk("t4_pulses", pulses - p0, 5);
        chk("t4_overflow", overflow, 0);
        chk("t4_count", event_count, 5);
        chk("t4_drained", sb.size(), 0);

        // asynchronous reset mid-operation
        sink_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(32'd0, 32'd20 + k, 64'h5000, 32'h300, 1'b1);
        #2;
        reset = 1'b1;
        sb.delete();
        exp_cnt = '0;
        #1;
        chk("t5_enable", {out_enable, out_valid}, 0);
        chk("t5_fields", {out_interrupt, out_exception}, 0);
        chk("t5_pc_inst", out_exceptionPC | 64'(out_exceptionInst), 0);
        chk("t5_overflow", overflow, 0);
        chk("t5_count", event_count, 0);
        chk("t5_coreid", out_coreid, CID);
        tick();
        reset = 1'b0;
        sink_ready = 1'b1;
        p0 = pulses;
        idle(10);
        chk("t5_no_pulses", pulses - p0, 0);
        chk("t5_count_after", event_count, 0);

        // counter wrap
        @(negedge clock);
        force dut.event_count = 32'hFFFFFFFF;
        #1;
        release dut.event_count;
        #1;
        chk("t6_preset", event_count, 32'hFFFFFFFF);
        tick();
        send(32'd3, 32'd0, 64'h6000, 32'h400, 1'b1);
        idle(4);
        chk("t6_wrap", event_count, 0);
        chk("final_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
